// File: rtl/dirctrl_pkg.sv
// Shared types and helpers for the slew-limited direction controller.
package dirctrl_pkg;

    // Widest speed word the helpers below handle.
    localparam int MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        HOLD  = 2'd2,
        DWELL = 2'd3
    } state_t;

    // Motion command as produced by the command decoder.
    typedef struct packed {
        logic       dir;    // 1 forward, 0 reverse
        logic [1:0] level;  // 0 stops, 1..3 select a speed
    } cmd_t;

    // Speed magnitude for a command level; level 0 means stop.
    function automatic int level_to_mag(input logic [1:0] level,
                                        input int speed1,
                                        input int speed2,
                                        input int speed3);
        case (level)
            2'd1:    return speed1;
            2'd2:    return speed2;
            2'd3:    return speed3;
            default: return 0;
        endcase
    endfunction

    // Two's complement negation; callers sign-extend into and truncate out of MAX_W.
    function automatic logic [MAX_W-1:0] twos_comp(input logic [MAX_W-1:0] value);
        return ~value + MAX_W'(1);
    endfunction

endpackage

// File: rtl/dirctrl_ramp_if.sv
// Command and motor-speed bundle between the decoder, the ramp controller and the drivers.
interface dirctrl_ramp_if
    import dirctrl_pkg::*;
#(
    parameter int WIDTH = 16
);
    cmd_t             cmds;
    logic             estop;
    logic [WIDTH-1:0] left_frwd;
    logic [WIDTH-1:0] right_back;
    logic             at_target;
    logic [1:0]       state_o;

    // Command side: decoder / test driver.
    modport master (
        output cmds, estop,
        input  left_frwd, right_back, at_target, state_o
    );

    // Controller side.
    modport slave (
        input  cmds, estop,
        output left_frwd, right_back, at_target, state_o
    );
endinterface

// File: rtl/ramp_tick_gen.sv
// Free-running divider that strobes tick once every RAMP_DIV clock cycles.
module ramp_tick_gen #(
    parameter int RAMP_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int            CW   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(RAMP_DIV - 1);

    logic [CW-1:0] cnt;

    // Count 0..RAMP_DIV-1 and wrap; with RAMP_DIV=1 the counter sits at 0.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/dirctrl_ramp.sv
// Direction controller with slew-rate limiting, reversal dwell and emergency stop.
// Maps {dir, level} to a signed speed and walks the motor output toward it
// by at most STEP per ramp tick, passing through zero and pausing there on reversal.
module dirctrl_ramp
    import dirctrl_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int SPEED1    = 102,
    parameter int SPEED2    = 218,
    parameter int SPEED3    = 402,
    parameter int STEP      = 16,
    parameter int RAMP_DIV  = 4,
    parameter int REV_DWELL = 8
) (
    input  logic           clk,
    input  logic           reset,
    dirctrl_ramp_if.slave  bus
);
    localparam int                    DW        = (REV_DWELL > 1) ? $clog2(REV_DWELL) : 1;
    localparam logic [DW-1:0]         DWELL_END = DW'(REV_DWELL - 1);
    localparam logic signed [WIDTH:0] STEP_W    = (WIDTH+1)'(STEP);

    state_t                  state, state_next;
    logic signed [WIDTH-1:0] cur, cur_next;
    logic signed [WIDTH-1:0] right_q, right_next;
    logic                    last_dir, last_dir_next;
    logic [DW-1:0]           dwell, dwell_next;
    logic                    at_target_q, at_target_next;

    logic                    tick;
    int                      mag;
    logic signed [WIDTH-1:0] target;
    logic signed [WIDTH-1:0] goal;
    logic                    tgt_dir;
    logic                    cur_pos;

    // Move c toward g by at most STEP; computed one bit wider so the difference cannot wrap.
    function automatic logic signed [WIDTH-1:0] step_toward(input logic signed [WIDTH-1:0] c,
                                                            input logic signed [WIDTH-1:0] g);
        logic signed [WIDTH:0] c_ext;
        logic signed [WIDTH:0] g_ext;
        logic signed [WIDTH:0] diff;
        logic signed [WIDTH:0] nxt;
        c_ext = (WIDTH+1)'(c);
        g_ext = (WIDTH+1)'(g);
        diff  = g_ext - c_ext;
        if (diff > STEP_W) begin
            nxt = c_ext + STEP_W;
        end else if (diff < -STEP_W) begin
            nxt = c_ext - STEP_W;
        end else begin
            nxt = g_ext;
        end
        return nxt[WIDTH-1:0];
    endfunction

    ramp_tick_gen #(
        .RAMP_DIV (RAMP_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Commanded speed: level 0 is zero whatever dir says.
    assign mag     = level_to_mag(bus.cmds.level, SPEED1, SPEED2, SPEED3);
    assign target  = bus.cmds.dir ? WIDTH'(mag) : WIDTH'(-mag);
    assign tgt_dir = ~target[WIDTH-1];
    assign cur_pos = ~cur[WIDTH-1];

    // Next-state, goal selection and ramp step; estop overrides everything last.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_next    = state;
        cur_next      = cur;
        last_dir_next = last_dir;
        dwell_next    = dwell;
        goal          = target;

        case (state)
            IDLE: begin
                if (target != '0) begin
                    state_next    = RAMP;
                    last_dir_next = tgt_dir;
                end
            end

            RAMP: begin
                // Head for zero first whenever the target lies across zero from us.
                if (cur != '0) begin
                    goal = (target == '0 || tgt_dir == cur_pos) ? target : '0;
                end else begin
                    goal = (target == '0 || tgt_dir == last_dir) ? target : '0;
                end
                if (tick) begin
                    cur_next = step_toward(cur, goal);
                end
                if (cur_next == target) begin
                    state_next = (target == '0) ? IDLE : HOLD;
                end else if (cur_next == '0 && target != '0 && tgt_dir != last_dir) begin
                    state_next = DWELL;
                    dwell_next = '0;
                end
            end

            HOLD: begin
                if (target != cur) begin
                    state_next = RAMP;
                end
            end

            DWELL: begin
                if (target == '0) begin
                    state_next = IDLE;
                end else if (tgt_dir == last_dir) begin
                    // Command swung back before the dwell ended: resume without waiting.
                    state_next = RAMP;
                end else if (dwell == DWELL_END) begin
                    state_next    = RAMP;
                    last_dir_next = tgt_dir;
                end else begin
                    dwell_next = dwell + DW'(1);
                end
            end

            default: begin
                state_next = IDLE;
                cur_next   = '0;
            end
        endcase

        if (bus.estop) begin
            state_next = IDLE;
            cur_next   = '0;
            dwell_next = '0;
        end

        right_next     = WIDTH'(twos_comp(MAX_W'(cur_next)));
        at_target_next = (cur_next == target) && (state_next == IDLE || state_next == HOLD);
    end

    // Controller state and both motor words update on the same edge, so they never skew.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cur         <= '0;
            right_q     <= '0;
            last_dir    <= 1'b1;
            dwell       <= '0;
            at_target_q <= 1'b1;
        end else begin
            state       <= state_next;
            cur         <= cur_next;
            right_q     <= right_next;
            last_dir    <= last_dir_next;
            dwell       <= dwell_next;
            at_target_q <= at_target_next;
        end
    end

    assign bus.left_frwd  = cur;
    assign bus.right_back = right_q;
    assign bus.at_target  = at_target_q;
    assign bus.state_o    = state;

endmodule

// File: tb/tb_dirctrl_ramp.sv
// Directed bench for dirctrl_ramp: a vector table for the ramp/reversal timeline
// plus hand-written sequences for dwell interrupt, estop, async reset and RAMP_DIV=1.
module tb_dirctrl_ramp;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RAMP  = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_DWELL = 2'd3;
    localparam int         NVEC     = 20;

    typedef struct {
        logic [2:0] cmds;
        logic       estop;
        int         adv;       // falling edges to advance before sampling
        int         exp_left;
        logic       exp_at;
        logic [1:0] exp_state;
    } vec_t;

    logic clk;
    logic reset;
    int   tests;
    int   failed;
    vec_t vecs [NVEC];

    dirctrl_ramp_if #(.WIDTH(16)) bus  ();
    dirctrl_ramp_if #(.WIDTH(16)) bus1 ();

    dirctrl_ramp dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    dirctrl_ramp #(.RAMP_DIV(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, failed);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic check_out(input string name, input int exp_left,
                             input logic exp_at, input logic [1:0] exp_state);
        int l;
        int r;
        l = $signed(bus.left_frwd);
        r = $signed(bus.right_back);
        check({name, "_left"},  l, exp_left);
        check({name, "_right"}, r, -exp_left);
        check({name, "_at"},    int'(bus.at_target), int'(exp_at));
        check({name, "_state"}, int'(bus.state_o), int'(exp_state));
    endtask

    task automatic wait_state(input logic [1:0] st, input int budget, input string name);
        int n;
        n = 0;
        while (bus.state_o !== st && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_reached"}, int'(bus.state_o === st), 1);
    endtask

    task automatic wait_moving(input int budget, input string name);
        int n;
        n = 0;
        while (bus.left_frwd == '0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_moved"}, int'(bus.left_frwd != '0), 1);
    endtask

    initial begin
        tests  = 0;
        failed = 0;

        // Timeline from reset release; ticks fall on edges 4, 8, 12, ...
        vecs[0]  = '{3'b000, 1'b0, 1,  0,    1'b1, ST_IDLE};
        vecs[1]  = '{3'b101, 1'b0, 1,  0,    1'b0, ST_RAMP};
        vecs[2]  = '{3'b101, 1'b0, 1,  0,    1'b0, ST_RAMP};
        vecs[3]  = '{3'b101, 1'b0, 1,  16,   1'b0, ST_RAMP};
        vecs[4]  = '{3'b101, 1'b0, 3,  16,   1'b0, ST_RAMP};
        vecs[5]  = '{3'b101, 1'b0, 1,  32,   1'b0, ST_RAMP};
        vecs[6]  = '{3'b101, 1'b0, 8,  64,   1'b0, ST_RAMP};
        vecs[7]  = '{3'b101, 1'b0, 8,  96,   1'b0, ST_RAMP};
        vecs[8]  = '{3'b101, 1'b0, 3,  96,   1'b0, ST_RAMP};
        vecs[9]  = '{3'b101, 1'b0, 1,  102,  1'b1, ST_HOLD};
        vecs[10] = '{3'b001, 1'b0, 1,  102,  1'b0, ST_RAMP};
        vecs[11] = '{3'b001, 1'b0, 3,  86,   1'b0, ST_RAMP};
        vecs[12] = '{3'b001, 1'b0, 20, 6,    1'b0, ST_RAMP};
        vecs[13] = '{3'b001, 1'b0, 4,  0,    1'b0, ST_DWELL};
        vecs[14] = '{3'b001, 1'b0, 7,  0,    1'b0, ST_DWELL};
        vecs[15] = '{3'b001, 1'b0, 1,  0,    1'b0, ST_RAMP};
        vecs[16] = '{3'b001, 1'b0, 3,  0,    1'b0, ST_RAMP};
        vecs[17] = '{3'b001, 1'b0, 1,  -16,  1'b0, ST_RAMP};
        vecs[18] = '{3'b001, 1'b0, 24, -102, 1'b1, ST_HOLD};
        vecs[19] = '{3'b001, 1'b0, 5,  -102, 1'b1, ST_HOLD};

        reset      = 1'b1;
        bus.cmds   = 3'b000;
        bus.estop  = 1'b0;
        bus1.cmds  = 3'b000;
        bus1.estop = 1'b0;
        repeat (2) @(negedge clk);
        check_out("reset", 0, 1'b1, ST_IDLE);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            bus.cmds  = vecs[i].cmds;
            bus.estop = vecs[i].estop;
            repeat (vecs[i].adv) @(negedge clk);
            check_out($sformatf("vec%0d", i), vecs[i].exp_left, vecs[i].exp_at, vecs[i].exp_state);
        end

        // Reverse toward +, then swing back during the dwell: no remaining dwell cycles.
        bus.cmds = 3'b101;
        wait_state(ST_DWELL, 60, "dwell_enter");
        repeat (2) @(negedge clk);
        check_out("dwell_mid", 0, 1'b0, ST_DWELL);
        bus.cmds = 3'b001;
        @(negedge clk);
        check_out("dwell_abort", 0, 1'b0, ST_RAMP);
        wait_moving(4, "dwell_abort");
        check_out("dwell_abort_step", -16, 1'b0, ST_RAMP);

        // Full reversal to level 3, then estop.
        bus.cmds = 3'b111;
        wait_state(ST_HOLD, 400, "hold402");
        check_out("hold402", 402, 1'b1, ST_HOLD);
        bus.estop = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_out($sformatf("estop%0d", k), 0, 1'b0, ST_IDLE);
        end
        bus.estop = 1'b0;
        wait_moving(8, "estop_release");
        check_out("estop_rel_s1", 16, 1'b0, ST_RAMP);
        repeat (4) @(negedge clk);
        check_out("estop_rel_s2", 32, 1'b0, ST_RAMP);

        // Asynchronous reset between edges, mid-ramp.
        #2 reset = 1'b1;
        #1;
        check_out("async_reset", 0, 1'b1, ST_IDLE);
        repeat (2) @(negedge clk);
        bus.cmds = 3'b000;
        reset    = 1'b0;
        @(negedge clk);
        check_out("post_reset", 0, 1'b1, ST_IDLE);

        // RAMP_DIV=1: one step every cycle, 218 after 14 steps.
        bus1.cmds = 3'b110;
        @(negedge clk);
        check("div1_enter_state", int'(bus1.state_o), int'(ST_RAMP));
        check("div1_enter_left", int'($signed(bus1.left_frwd)), 0);
        for (int k = 1; k <= 14; k++) begin
            int exp_v;
            @(negedge clk);
            exp_v = (k == 14) ? 218 : 16 * k;
            check($sformatf("div1_left%0d", k), int'($signed(bus1.left_frwd)), exp_v);
            check($sformatf("div1_right%0d", k), int'($signed(bus1.right_back)), -exp_v);
        end
        check("div1_state", int'(bus1.state_o), int'(ST_HOLD));
        check("div1_at", int'(bus1.at_target), 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
